// File: rtl/monster_spawn_scheduler_if.sv
// Spawn handshake bundle between the scheduler (master) and the monster
// instances / game control (slave).
interface monster_spawn_scheduler_if #(
  parameter int NUM_SLOTS = 8
);
  logic                 enable;
  logic [NUM_SLOTS-1:0] monster_done;
  logic                 spawn_ack;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic                 spawn_valid;
  logic [7:0]           wave_num;

  modport master (
    input  enable,
    input  monster_done,
    input  spawn_ack,
    output spawn_sel,
    output spawn_valid,
    output wave_num
  );

  modport slave (
    output enable,
    output monster_done,
    output spawn_ack,
    input  spawn_sel,
    input  spawn_valid,
    input  wave_num
  );
endinterface

// File: rtl/monster_spawn_scheduler.sv
// Round-robin spawn arbiter with a cooldown between spawns and optional wave
// grouping (macro SPAWN_WAVE_EN adds the PAUSE state, wave_cnt and wave_num).
module monster_spawn_scheduler #(
  parameter int NUM_SLOTS  = 8,
  parameter int COOLDOWN   = 25_000_000,
  parameter int WAVE_SIZE  = 6,
  parameter int WAVE_PAUSE = 100_000_000,
  parameter int CNT_W      = 28
) (
  input  logic                      Clk,
  input  logic                      Reset,
  monster_spawn_scheduler_if.master bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);

`ifdef SPAWN_WAVE_EN
  localparam int WCNT_W = (WAVE_SIZE > 1) ? $clog2(WAVE_SIZE) : 1;
  localparam logic [CNT_W-1:0]  PAUSE_LAST = CNT_W'(WAVE_PAUSE - 1);
  localparam logic [WCNT_W-1:0] WAVE_LAST  = WCNT_W'(WAVE_SIZE - 1);

  typedef enum logic [1:0] {
    ST_COOL  = 2'd0,
    ST_READY = 2'd1,
    ST_GRANT = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  logic [WCNT_W-1:0] wave_cnt_q, wave_cnt_d;
  logic [7:0]        wave_num_q, wave_num_d;
`else
  typedef enum logic [1:0] {
    ST_COOL  = 2'd0,
    ST_READY = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  // Wave parameters have no effect in this build.
  logic unused_wave_cfg;
  assign unused_wave_cfg = (WAVE_SIZE > 0) && (WAVE_PAUSE > 0);
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [NUM_SLOTS-1:0] sel_q, sel_d;
  logic                 valid_q, valid_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     ptr_after;

  // First set done bit at or after rr_ptr, wrapping modulo NUM_SLOTS.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
      if (!pick_found && bus.monster_done[IDX_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  assign ptr_after = (int'(gidx_q) == NUM_SLOTS - 1) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
`ifdef SPAWN_WAVE_EN
    wave_cnt_d = wave_cnt_q;
    wave_num_d = wave_num_q;
`endif

    case (state_q)
      ST_COOL: begin
        if (bus.enable) begin
          if (cnt_q == COOL_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_READY: begin
        if (bus.enable && pick_found) begin
          sel_d   = NUM_SLOTS'(1) << pick_idx;
          valid_d = 1'b1;
          gidx_d  = pick_idx;
          state_d = ST_GRANT;
        end
      end

      // A grant is only ever closed by the ack, never by enable or done.
      ST_GRANT: begin
        if (bus.spawn_ack) begin
          sel_d    = '0;
          valid_d  = 1'b0;
          rr_ptr_d = ptr_after;
          cnt_d    = '0;
`ifdef SPAWN_WAVE_EN
          if (wave_cnt_q == WAVE_LAST) begin
            wave_cnt_d = '0;
            wave_num_d = (wave_num_q == 8'hFF) ? wave_num_q : wave_num_q + 8'd1;
            state_d    = ST_PAUSE;
          end else begin
            wave_cnt_d = wave_cnt_q + 1'b1;
            state_d    = ST_COOL;
          end
`else
          state_d = ST_COOL;
`endif
        end
      end

`ifdef SPAWN_WAVE_EN
      // The pause stands in for the cooldown before the next wave.
      ST_PAUSE: begin
        if (bus.enable) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_COOL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_COOL;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
`ifdef SPAWN_WAVE_EN
      wave_cnt_q <= '0;
      wave_num_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
`ifdef SPAWN_WAVE_EN
      wave_cnt_q <= wave_cnt_d;
      wave_num_q <= wave_num_d;
`endif
    end
  end

  assign bus.spawn_sel   = sel_q;
  assign bus.spawn_valid = valid_q;
`ifdef SPAWN_WAVE_EN
  assign bus.wave_num    = wave_num_q;
`else
  assign bus.wave_num    = 8'd0;
`endif

endmodule

// File: tb/tb_monster_spawn_scheduler.sv
// Scoreboard bench for monster_spawn_scheduler: a countdown-based reference
// model predicts each grant; a negedge monitor matches DUT grants against it.
module tb_monster_spawn_scheduler;
  localparam int N  = 4;
  localparam int CD = 4;
  localparam int WS = 3;
  localparam int WP = 10;
  localparam int CW = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  monster_spawn_scheduler_if #(.NUM_SLOTS(N)) bus ();

  monster_spawn_scheduler #(
    .NUM_SLOTS (N),
    .COOLDOWN  (CD),
    .WAVE_SIZE (WS),
    .WAVE_PAUSE(WP),
    .CNT_W     (CW)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0] sel;
    int           cyc;
    int           waves;
  } grant_t;

  grant_t       exp_q[$];
  logic [N-1:0] glog_sel[$];
  int           glog_cyc[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: phase 0 = counting down, 1 = ready, 2 = granted.
  int m_phase, m_left, m_ptr, m_gidx, m_inwave, m_waves;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    grant_t       e;
    logic [N-1:0] d;
    int           pick;
    cyc++;
    d    = bus.monster_done;
    pick = -1;
    if (Reset) begin
      m_phase  = 0;
      m_left   = CD;
      m_ptr    = 0;
      m_gidx   = 0;
      m_inwave = 0;
      m_waves  = 0;
      return;
    end
    case (m_phase)
      0: if (bus.enable) begin
        m_left--;
        if (m_left == 0) m_phase = 1;
      end
      1: if (bus.enable && d != '0) begin
        for (int k = 0; k < N; k++)
          if (pick < 0 && ((d >> ((m_ptr + k) % N)) & N'(1)) != '0) pick = (m_ptr + k) % N;
        m_gidx  = pick;
        e.sel   = N'(1) << pick;
        e.cyc   = cyc;
        e.waves = m_waves;
        exp_q.push_back(e);
        m_phase = 2;
      end
      default: if (bus.spawn_ack) begin
        m_ptr = (m_gidx + 1) % N;
        m_inwave++;
`ifdef SPAWN_WAVE_EN
        if (m_inwave == WS) begin
          m_inwave = 0;
          if (m_waves < 255) m_waves++;
          m_left = WP;
        end else begin
          m_left = CD;
        end
`else
        m_left = CD;
`endif
        m_phase = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Monitor: invariants every cycle, scoreboard match on each new grant.
  initial begin
    logic         prev_v;
    logic [N-1:0] prev_sel;
    grant_t       e;
    prev_v   = 1'b0;
    prev_sel = '0;
    forever begin
      @(negedge Clk);
      chk("valid_vs_sel", int'(bus.spawn_valid), int'(|bus.spawn_sel));
      chk("sel_onehot0", int'($onehot0(bus.spawn_sel)), 1);
      if (bus.spawn_valid && prev_v)
        chk("grant_stable", int'(bus.spawn_sel), int'(prev_sel));
      if (bus.spawn_valid && !prev_v) begin
        glog_sel.push_back(bus.spawn_sel);
        glog_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_grant_sel", int'(bus.spawn_sel), 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_sel", int'(bus.spawn_sel), int'(e.sel));
          chk("grant_cycle", cyc, e.cyc);
          chk("grant_wave_num", int'(bus.wave_num), e.waves);
        end
      end
      prev_v   = bus.spawn_valid;
      prev_sel = bus.spawn_sel;
    end
  end

  task automatic wait_grant(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge Clk);
      if (bus.spawn_valid) return;
    end
    chk(name, 0, 1);
  endtask

  initial begin
    int t0;
    int exp_waves;
    Reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.monster_done = '0;
    bus.spawn_ack    = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset_valid", int'(bus.spawn_valid), 0);
    chk("reset_sel", int'(bus.spawn_sel), 0);
    chk("reset_wave_num", int'(bus.wave_num), 0);

    // All slots requesting, ack one cycle after each grant.
    glog_sel.delete();
    glog_cyc.delete();
    Reset            = 1'b0;
    bus.enable       = 1'b1;
    bus.monster_done = 4'b1111;
    for (int i = 0; i < 70; i++) begin
      @(negedge Clk);
      bus.spawn_ack = bus.spawn_valid;
    end
    bus.spawn_ack = 1'b0;
    chk("a_grant_count_ge5", int'(glog_sel.size() >= 5), 1);
    if (glog_sel.size() >= 5) begin
      chk("a_seq0", int'(glog_sel[0]), 4'b0001);
      chk("a_seq1", int'(glog_sel[1]), 4'b0010);
      chk("a_seq2", int'(glog_sel[2]), 4'b0100);
      chk("a_seq3", int'(glog_sel[3]), 4'b1000);
      chk("a_seq4", int'(glog_sel[4]), 4'b0001);
      chk("a_first_grant_cycle", glog_cyc[1] - glog_cyc[0], CD + 2);
`ifdef SPAWN_WAVE_EN
      chk("a_wave_gap", glog_cyc[3] - glog_cyc[2], WP + 2);
`else
      chk("a_wave_gap", glog_cyc[3] - glog_cyc[2], CD + 2);
`endif
    end
`ifdef SPAWN_WAVE_EN
    exp_waves = 3;
`else
    exp_waves = 0;
`endif
    chk("a_wave_num", int'(bus.wave_num), exp_waves);

    // Single requester: first grant exactly 5 cycles after reset release.
    Reset            = 1'b1;
    bus.monster_done = 4'b0100;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("b_not_early", int'(bus.spawn_valid), 0);
    @(negedge Clk);
    chk("b_valid_at_5", int'(bus.spawn_valid), 1);
    chk("b_sel_at_5", int'(bus.spawn_sel), 4'b0100);
    bus.spawn_ack = 1'b1;
    @(negedge Clk);
    bus.spawn_ack    = 1'b0;
    bus.monster_done = 4'b0101;
    wait_grant("b_second_grant_timeout", 20);
    chk("b_rr_wrap_sel", int'(bus.spawn_sel), 4'b0001);

    // Hold the grant 20 cycles while enable toggles and the done bit clears.
    for (int i = 0; i < 20; i++) begin
      bus.enable       = i[0];
      bus.monster_done = 4'($urandom) & 4'b1110;
      @(negedge Clk);
      chk("c_hold_valid", int'(bus.spawn_valid), 1);
      chk("c_hold_sel", int'(bus.spawn_sel), 4'b0001);
    end
    bus.enable       = 1'b1;
    bus.monster_done = 4'b1111;
    bus.spawn_ack    = 1'b1;
    @(negedge Clk);
    t0            = cyc;
    bus.spawn_ack = 1'b0;

    // Freeze the cooldown for 6 cycles: grant slips by exactly 6.
    @(negedge Clk);
    bus.enable = 1'b0;
    repeat (6) @(negedge Clk);
    bus.enable = 1'b1;
    wait_grant("d_grant_timeout", 20);
    chk("d_delayed_grant", cyc - t0, CD + 1 + 6);
    bus.spawn_ack = 1'b1;
    @(negedge Clk);
    bus.spawn_ack = 1'b0;
    wait_grant("e_grant_timeout", 30);
`ifdef SPAWN_WAVE_EN
    chk("e_wave_before_reset", int'(bus.wave_num), 1);
`else
    chk("e_wave_before_reset", int'(bus.wave_num), 0);
`endif

    // Reset in the middle of a grant.
    Reset = 1'b1;
    @(negedge Clk);
    chk("e_reset_valid", int'(bus.spawn_valid), 0);
    chk("e_reset_sel", int'(bus.spawn_sel), 0);
    chk("e_reset_wave_num", int'(bus.wave_num), 0);
    Reset = 1'b0;
    wait_grant("e_regrant_timeout", 20);
    chk("e_regrant_sel", int'(bus.spawn_sel), 4'b0001);
    bus.spawn_ack = 1'b1;
    @(negedge Clk);
    bus.spawn_ack = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Reset         = ($urandom_range(0, 499) == 0);
      bus.enable    = ($urandom_range(0, 3) != 0);
      bus.spawn_ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) bus.monster_done = 4'($urandom);
    end
    Reset         = 1'b0;
    bus.spawn_ack = 1'b0;
    repeat (2) @(negedge Clk);
    chk("final_pending_grants", exp_q.size(), 0);
    chk("final_wave_num", int'(bus.wave_num), m_waves);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monster_spawn_scheduler.md
# monster_spawn_scheduler

Round-robin spawn arbiter that shares the single spawn opportunity among NUM_SLOTS monster slots. It enforces a minimum cooldown between spawns and groups spawns into waves separated by a longer pause. It sits between the per-monster `done` flags and the monster instances' spawn inputs, and grants one slot at a time over a valid/ack handshake.

## Interface
- NUM_SLOTS, 8: number of monster slots (requesters), 2..16
- COOLDOWN, 25_000_000: cycles between accepted spawns (0.5 s at 50 MHz), ≥2
- WAVE_SIZE, 6: spawns per wave, ≥1
- WAVE_PAUSE, 100_000_000: cycles of inter-wave pause, ≥2
- CNT_W, 28: counter width; must hold max(COOLDOWN, WAVE_PAUSE)
- Clk  in  1  system clock; all logic on the rising edge
- Reset  in  1  synchronous, active-high reset
- enable  in  1  game running; gates counting and new grants
- monster_done  in  NUM_SLOTS  bit i=1: slot i is idle and may be spawned
- spawn_ack  in  1  granted slot has accepted the spawn (one-cycle pulse expected; level tolerated)
- spawn_sel  out  NUM_SLOTS  one-hot granted slot; all zero when no grant
- spawn_valid  out  1  grant outstanding
- wave_num  out  8  completed waves, saturating at 255

## Operation
- States: COOL, READY, GRANT, PAUSE.
- Reset: state=COOL, counter=0, rr_ptr=0, spawn_sel=0, spawn_valid=0, wave_num=0, wave_cnt=0.
- COOL: counter += 1 each cycle while enable=1 and holds while enable=0. At counter==COOLDOWN-1 (and enable=1), go to READY with counter=0.
- READY: if enable=1 and any monster_done bit is set, select the first set bit at index rr_ptr, rr_ptr+1, … with wrap mod NUM_SLOTS. Register it as one-hot spawn_sel, set spawn_valid=1, go to GRANT. Otherwise wait, with no timeout.
- GRANT: spawn_sel and spawn_valid are held stable until spawn_ack=1. They are held even if enable falls or the granted done bit drops; a grant is never retracted.
- On the ack cycle:
  - spawn_valid→0 and spawn_sel→0 on the next edge.
  - rr_ptr = (granted index + 1) mod NUM_SLOTS.
  - wave_cnt += 1.
  - If the new wave_cnt == WAVE_SIZE: wave_cnt=0, wave_num += 1 (saturating), go to PAUSE with counter=0. Otherwise go to COOL with counter=0.
- PAUSE: counts like COOL (gated by enable) up to WAVE_PAUSE-1, then goes to READY with counter=0. The inter-wave pause replaces, not adds to, the cooldown.
- spawn_ack outside GRANT is ignored.
- Reset mid-grant: the grant is dropped immediately on that edge, and all state returns to reset values.

## Timing
- Arbitration latency: done bit sampled at edge N in READY → spawn_valid=1 with spawn_sel valid after edge N. spawn_sel is registered and never combinational.
- spawn_ack high at edge M → spawn_valid=0 after edge M. The earliest next grant follows COOLDOWN counting cycles plus 1 READY cycle.
- Minimum spawn-to-spawn spacing: COOLDOWN+2 cycles with enable=1 and requests pending.
- spawn_sel is always one-hot or zero; spawn_valid==|spawn_sel at every edge.
- Counter comparisons are equality at CNT_W bits; the counter never wraps.

## Configuration
- SPAWN_WAVE_EN defined: wave logic and PAUSE state are present as described above.
- SPAWN_WAVE_EN undefined:
  - The PAUSE state and wave_cnt are removed, and wave_num is tied to 0.
  - Every acknowledged grant goes to COOL.
  - WAVE_SIZE and WAVE_PAUSE are ignored.

## Test plan
Bench parameters: NUM_SLOTS=4, COOLDOWN=4, WAVE_SIZE=3, WAVE_PAUSE=10, SPAWN_WAVE_EN defined.
- Reset, then enable=1, monster_done=4'b1111, ack one cycle after each valid → spawn_sel sequence 0001, 0010, 0100, then PAUSE (10 cycles), then 1000, 0001. wave_num=1 after the 3rd ack.
- monster_done=4'b0100 only, from reset → first grant 0100 exactly 5 cycles after reset release. rr_ptr becomes 3, so the next grant with done=4'b0101 is 0001.
- Hold spawn_ack=0 for 20 cycles in GRANT while toggling enable and clearing the granted done bit → spawn_sel/spawn_valid stay constant; the counter stays 0.
- enable=0 for 6 cycles mid-COOL → counter freezes, and the grant is delayed by exactly 6 cycles.
- Assert Reset during GRANT → spawn_valid=0, spawn_sel=0, wave_num=0 after that edge; the next grant is again 0001 (with done=4'b1111).
- Build without SPAWN_WAVE_EN, done=4'b1111 → 6 consecutive grants, each COOLDOWN+2 cycles apart with no pause; wave_num stays 0.
